// File: rtl/a0_uart_tx.sv
// Streams every change of the core's a0 value off-chip as an 8N1 UART frame.
// Change detector -> small circular FIFO -> IDLE/START/DATA/STOP serialiser.
module a0_uart_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W  = FIFO_ADDR_WIDTH + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]      shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic [DATA_WIDTH-1:0]      prev_q;
    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0]           count_q;
    logic                       overflow_q;

    logic push_req, push_ok, pop, baud_last;

    // Push/pop handshake: push_req is a one-cycle request (data_i != prev);
    // the FIFO accepts it when not full, or when full but popping the same
    // cycle. pop is asserted only from IDLE with a non-empty FIFO.
    assign push_req  = (data_i != prev_q);
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign push_ok   = push_req && ((count_q != CNT_FULL) || pop);
    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            prev_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q <= data_i;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            if (push_req && !push_ok) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (rst_i && push_ok) mem[wptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[rptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) state_d = STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is derived from the next state so tx_o is a pure flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE);
    assign overflow_o   = overflow_q;
    assign fifo_count_o = count_q;

endmodule
